// File: rtl/conv_window_ctrl_if.sv
// rtl/conv_window_ctrl_if.sv - pixel-stream and window-presentation signals of the conv window controller
interface conv_window_ctrl_if #(
    parameter int CW = 5,
    parameter int RW = 5
);
    logic          pix_valid;
    logic          pix_ready;
    logic          rb_en;
    logic          win_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    // Controller side: accepts pixels, presents windows.
    modport master (
        input  pix_valid,
        output pix_ready,
        output rb_en,
        output win_valid,
        input  win_ready,
        output win_row,
        output win_col
    );

    // Environment side: pixel source plus MAC array.
    modport slave (
        output pix_valid,
        input  pix_ready,
        input  rb_en,
        input  win_valid,
        output win_ready,
        input  win_row,
        input  win_col
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - sliding-window sequencing controller; optional window counter under CONV_WIN_CNT_EN
module conv_window_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    conv_window_ctrl_if.master win,
    output logic               busy,
    output logic               frame_done
`ifdef CONV_WIN_CNT_EN
    ,
    output logic [15:0]        win_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          win_full;

    // A held, unconsumed window blocks the stream so its registers cannot shift.
    assign win.pix_ready = (state == S_RUN) && !(win.win_valid && !win.win_ready);
    assign accept        = win.pix_valid && win.pix_ready;
    assign win.rb_en     = accept;
    assign win_full      = (row >= ROW_MIN) && (col >= COL_MIN);
    assign busy          = (state != S_IDLE);

    // Frame sequencing, raster position tracking and window presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            row           <= '0;
            col           <= '0;
            win.win_valid <= 1'b0;
            win.win_row   <= '0;
            win.win_col   <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                state <= S_DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!win.win_valid || win.win_ready) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The window registers shift on the same edge as the accept, so the
            // patch is complete one cycle later; coordinates use the pre-increment position.
            if (accept && win_full) begin
                win.win_valid <= 1'b1;
                win.win_row   <= row - ROW_MIN;
                win.win_col   <= col - COL_MIN;
            end else if (win.win_ready) begin
                win.win_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_WIN_CNT_EN
    // Count consumed windows; value holds after frame end until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            win_cnt <= '0;
        end else if (win.win_valid && win.win_ready) begin
            win_cnt <= win_cnt + 16'd1;
        end
    end
`endif

endmodule
